// File: rtl/bar_loader_pkg.sv
// Shared types and defaults for the spectrum bar frame loader.
// Holds the loader FSM state encoding and the height clamp helper.
package bar_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int DEF_N_BARS = 20;
    localparam int DEF_H_W    = 6;
    localparam int DEF_RD_LAT = 3;
    localparam int TAG_W      = 6;
    localparam int CNT_W      = 7;

    function automatic logic [15:0] sat_h(input logic [15:0] v, input logic [15:0] max_h);
        return (v > max_h) ? max_h : v;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delays a {valid, bar index} tag by the RAM read latency so each
// returning word is written into the right back-buffer slot.
module rd_tag_pipe #(
    parameter int RD_LAT = 3,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [RD_LAT-1:0]            valid_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
            for (int s = 1; s < RD_LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
                idx_q[s]   <= idx_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign idx_o   = idx_q[RD_LAT-1];

endmodule

// File: rtl/bar_frame_loader.sv
// Sweeps bar heights from the bar RAM into a back buffer and swaps it atomically into the
// front buffer shown by VGA. Optional peak-hold build: define PEAK_HOLD_EN.
//   state   | meaning
//   IDLE    | front buffer stable, waiting for a data_back rising edge
//   LOAD    | issuing RAM addresses and capturing returned words into back buffer
//   PENDING | back buffer complete, waiting for the swap point
module bar_frame_loader
    import bar_loader_pkg::*;
#(
    parameter int N_BARS        = DEF_N_BARS,
    parameter int H_W           = DEF_H_W,
    parameter int ADDR_W        = 6,
    parameter int BASE_ADDR     = 0,
    parameter int RD_LAT        = DEF_RD_LAT,
    parameter int MAX_H         = 63,
    parameter int SWAP_ON_FRAME = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_back_i,
    input  logic                    frame_tick_i,
    output logic [ADDR_W-1:0]       ram_rdaddress_o,
    input  logic [H_W-1:0]          ram_q_i,
    output logic [N_BARS*H_W-1:0]   height_o,
    output logic [N_BARS*H_W-1:0]   peak_o,
    output logic                    busy_o,
    output logic                    control_bit_o,
    output logic                    frame_valid_o,
    output logic [7:0]              drop_cnt_o
);

    state_t                     state_q, state_d;
    logic                       db_q;
    logic                       trig;
    logic [CNT_W-1:0]           idx_q;
    logic [ADDR_W-1:0]          rdaddr_q;
    logic [N_BARS-1:0][H_W-1:0] back_q;
    logic [N_BARS-1:0][H_W-1:0] front_q;
    logic                       control_q;
    logic                       frame_valid_q;
    logic [7:0]                 drop_q;
    logic                       busy, issue, swap, last_cap;
    logic                       tag_valid;
    logic [TAG_W-1:0]           tag_idx;
    logic [H_W-1:0]             ram_clamped;

    assign trig        = data_back_i & ~db_q;
    assign last_cap    = tag_valid && (tag_idx == TAG_W'(N_BARS - 1));
    assign ram_clamped = H_W'(sat_h(16'(ram_q_i), 16'(MAX_H)));

    rd_tag_pipe #(.RD_LAT(RD_LAT), .IDX_W(TAG_W)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .valid_i (issue),
        .idx_i   (idx_q[TAG_W-1:0]),
        .valid_o (tag_valid),
        .idx_o   (tag_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig)     state_d = LOAD;
            LOAD:    if (last_cap) state_d = PENDING;
            PENDING: if (swap)     state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        issue = (state_q == LOAD) && (idx_q < CNT_W'(N_BARS));
        swap  = (state_q == PENDING) && ((SWAP_ON_FRAME == 0) || frame_tick_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q          <= 1'b1;
            idx_q         <= '0;
            rdaddr_q      <= ADDR_W'(BASE_ADDR);
            back_q        <= '0;
            front_q       <= '0;
            control_q     <= 1'b1;
            frame_valid_q <= 1'b0;
            drop_q        <= '0;
        end else begin
            db_q      <= data_back_i;
            control_q <= ~busy;
            if ((state_q == IDLE) && trig) begin
                idx_q <= '0;
            end else if (issue) begin
                idx_q    <= idx_q + CNT_W'(1);
                rdaddr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
            end
            // A trigger coinciding with the swap is still counted as dropped.
            if (trig && busy && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
            for (int k = 0; k < N_BARS; k++) begin
                if (tag_valid && (tag_idx == TAG_W'(k))) back_q[k] <= ram_clamped;
            end
            if (swap) begin
                front_q       <= back_q;
                frame_valid_q <= 1'b1;
            end
        end
    end

`ifdef PEAK_HOLD_EN
    logic [N_BARS-1:0][H_W-1:0] peak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            for (int k = 0; k < N_BARS; k++) begin
                if (swap) begin
                    if (back_q[k] > peak_q[k]) peak_q[k] <= back_q[k];
                end else if (frame_tick_i && (peak_q[k] != '0)) begin
                    peak_q[k] <= peak_q[k] - H_W'(1);
                end
            end
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = front_q;
`endif

    assign ram_rdaddress_o = rdaddr_q;
    assign height_o        = front_q;
    assign busy_o          = busy;
    assign control_bit_o   = control_q;
    assign frame_valid_o   = frame_valid_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_bar_frame_loader.sv
// Self-checking bench: dut0 swaps right after loading (MAX_H=40), dut1 swaps on frame ticks.
`timescale 1ns/1ps
module tb_bar_frame_loader;

    localparam int NB = 20;
    localparam int HW = 6;
    localparam int AW = 6;
    localparam int HB = NB * HW;

    logic          clk = 1'b0;
    logic          reset;
    logic          db0, db1, tick;
    logic [AW-1:0] addr0, addr1;
    logic [HW-1:0] q0, q1;
    logic [HB-1:0] h0, h1, p0, p1;
    logic          busy0, busy1, cb0, cb1, fv0, fv1;
    logic [7:0]    dc0, dc1;

    logic [HW-1:0] mem [64];
    logic [HW-1:0] d0a, d0b, d1a, d1b;

    int n_vec = 0;
    int n_err = 0;
    int exp_drop0, exp_drop1;
    logic [HB-1:0] front0, front1;
    logic [HB-1:0] exp_h0_q[$];
    logic [HB-1:0] exp_h1_q[$];
    logic [AW-1:0] exp_a_q[$];

    typedef struct {
        int            bar;
        logic [HW-1:0] ram;
        logic [HW-1:0] exp;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    // RAM model: word for the address on the port is sampled RD_LAT edges later.
    always @(posedge clk) begin
        d0a <= mem[addr0];
        d0b <= d0a;
        d1a <= mem[addr1];
        d1b <= d1a;
    end
    assign q0 = d0b;
    assign q1 = d1b;

    bar_frame_loader #(.N_BARS(NB), .H_W(HW), .ADDR_W(AW), .BASE_ADDR(0), .RD_LAT(3),
                       .MAX_H(40), .SWAP_ON_FRAME(0)) dut0 (
        .clk(clk), .reset(reset), .data_back_i(db0), .frame_tick_i(tick),
        .ram_rdaddress_o(addr0), .ram_q_i(q0), .height_o(h0), .peak_o(p0),
        .busy_o(busy0), .control_bit_o(cb0), .frame_valid_o(fv0), .drop_cnt_o(dc0));

    bar_frame_loader #(.N_BARS(NB), .H_W(HW), .ADDR_W(AW), .BASE_ADDR(0), .RD_LAT(3),
                       .MAX_H(63), .SWAP_ON_FRAME(1)) dut1 (
        .clk(clk), .reset(reset), .data_back_i(db1), .frame_tick_i(tick),
        .ram_rdaddress_o(addr1), .ram_q_i(q1), .height_o(h1), .peak_o(p1),
        .busy_o(busy1), .control_bit_o(cb1), .frame_valid_o(fv1), .drop_cnt_o(dc1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [HB-1:0] model(input int mx);
        logic [HB-1:0] e;
        e = '0;
        for (int k = 0; k < NB; k++)
            e[k*HW +: HW] = (int'(mem[k]) > mx) ? HW'(mx) : mem[k];
        return e;
    endfunction

    task automatic clear_model();
        exp_drop0 = 0;
        exp_drop1 = 0;
        front0 = '0;
        front1 = '0;
        exp_h0_q.delete();
        exp_h1_q.delete();
        exp_a_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_h0"}, h0, 0);
        chk({tag, "_p0"}, p0, 0);
        chk({tag, "_addr0"}, addr0, 0);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_cb0"}, cb0, 1);
        chk({tag, "_fv0"}, fv0, 0);
        chk({tag, "_dc0"}, dc0, 0);
        chk({tag, "_h1"}, h1, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_dc1"}, dc1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_model();
        step();
    endtask

    // Trigger dut0 (db0 must be low) and follow it to the swap at t+24.
    task automatic load0(input bit chk_addr, input int n_extra);
        exp_h0_q.push_back(model(40));
        if (chk_addr)
            for (int k = 0; k < NB; k++) exp_a_q.push_back(AW'(k));
        db0 = 1'b1;
        step();
        db0 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (chk_addr && c <= NB) chk("rdaddr", addr0, exp_a_q.pop_front());
            if (chk_addr && c == 22) chk("rdaddr_hold", addr0, NB - 1);
            if (c == 23) begin
                chk("h0_before_swap", h0, front0);
                chk("busy0_pending", busy0, 1);
            end
            db0 = (c <= 2 * n_extra) ? (c % 2 == 1) : 1'b0;
        end
        exp_drop0 += n_extra;
        front0 = exp_h0_q.pop_front();
        chk("h0_swap", h0, front0);
        chk("busy0_after_swap", busy0, 0);
        chk("fv0", fv0, 1);
        chk("dc0", dc0, exp_drop0);
`ifndef PEAK_HOLD_EN
        chk("p0_follows_h0", p0, front0);
`endif
    endtask

    // Trigger dut1 (db1 must be low) and run until it sits in PENDING.
    task automatic load1(input bit tick_in_load);
        exp_h1_q.push_back(model(63));
        db1 = 1'b1;
        step();
        db1 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick = (tick_in_load && c == 5);
            step();
        end
        tick = 1'b0;
        chk("busy1_pending", busy1, 1);
    endtask

    task automatic swap1(input bit with_trig);
        chk("h1_hold", h1, front1);
        tick = 1'b1;
        if (with_trig) db1 = 1'b1;
        step();
        tick = 1'b0;
        front1 = exp_h1_q.pop_front();
        if (with_trig) exp_drop1++;
        chk("h1_swap", h1, front1);
        chk("busy1_after_swap", busy1, 0);
        chk("fv1", fv1, 1);
        chk("cb1_low", cb1, 0);
        chk("dc1", dc1, exp_drop1);
        step();
        chk("cb1_high", cb1, 1);
        db1 = 1'b0;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, expected finish before 400us");
        $fatal(1);
    end

    initial begin
        vt[0] = '{5, 6'd63, 6'd40};
        vt[1] = '{6, 6'd39, 6'd39};
        vt[2] = '{7, 6'd40, 6'd40};
        vt[3] = '{8, 6'd41, 6'd40};
        vt[4] = '{0, 6'd0,  6'd0};
        vt[5] = '{19, 6'd62, 6'd40};
        vt[6] = '{1, 6'd1,  6'd1};

        reset = 1'b1;
        db0 = 1'b0;
        db1 = 1'b0;
        tick = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = HW'(k + 1);
        clear_model();
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();
        step();

        // Basic load, immediate swap, address sequence and latency.
        load0(1'b1, 0);

        // Swap deferred to a frame tick; a tick during LOAD is ignored.
        load1(1'b1);
        repeat (100) step();
        chk("fv1_before", fv1, 0);
        chk("busy1_wait", busy1, 1);
        swap1(1'b1);
        chk("p1_first_swap", p1, front1);
        repeat (3) step();
        chk("busy1_no_reload", busy1, 0);

        // Clamp table through dut0.
        for (int i = 0; i < 7; i++) mem[vt[i].bar] = vt[i].ram;
        load0(1'b0, 0);
        for (int i = 0; i < 7; i++)
            chk($sformatf("clamp_bar%0d", vt[i].bar), h0[vt[i].bar*HW +: HW], vt[i].exp);

        // Edges during LOAD are dropped and do not disturb the frame.
        for (int k = 0; k < 64; k++) mem[k] = HW'((3 * k + 7) % 64);
        load0(1'b0, 3);

        // Saturation of the drop counter while dut1 waits in PENDING.
        load1(1'b0);
        for (int i = 0; i < 300; i++) begin
            db1 = 1'b1;
            step();
            db1 = 1'b0;
            step();
        end
        exp_drop1 = (exp_drop1 + 300 > 255) ? 255 : exp_drop1 + 300;
        chk("dc1_sat", dc1, exp_drop1);
        chk("busy1_still", busy1, 1);
        swap1(1'b0);

        // Reset in the middle of a load; data_back held high through reset.
        for (int k = 0; k < 64; k++) mem[k] = HW'(30 - (k % 20));
        db0 = 1'b1;
        repeat (10) step();
        reset = 1'b1;
        #1;
        chk_reset_vals("midload");
        step();
        step();
        reset = 1'b0;
        clear_model();
        repeat (40) step();
        chk("no_load_held_high", busy0, 0);
        chk("no_swap_after_rst", h0, 0);
        chk("fv0_after_rst", fv0, 0);
        db0 = 1'b0;
        step();
        load0(1'b0, 0);

`ifdef PEAK_HOLD_EN
        do_reset();
        for (int k = 0; k < 64; k++) mem[k] = HW'(k + 1);
        mem[0] = 6'd30;
        load1(1'b0);
        swap1(1'b0);
        chk("peak_f1", p1[HW-1:0], 30);
        mem[0] = 6'd10;
        load1(1'b0);
        swap1(1'b0);
        chk("peak_f2", p1[HW-1:0], 30);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
            chk($sformatf("peak_decay%0d", i), p1[HW-1:0], 29 - i);
        end
        chk("peak_floor_bar1", p1[2*HW-1:HW], 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
